// File: rtl/audio_mixer_pkg.sv
// Shared constants, scan-state encoding and width helper for the audio mixer.
package audio_mixer_pkg;

  localparam logic [7:0] IDXPORT_DEF = 8'hF6;
  localparam logic [7:0] DATPORT_DEF = 8'hF7;
  localparam logic [7:0] CLIPIDX     = 8'hFE;

  typedef enum logic {
    ACC  = 1'b0,
    DUMP = 1'b1
  } scan_state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/audio_mixer_seq_sd_dac.sv
// First-order sigma-delta DAC: signed sample in, one-bit stream out.
module sd_dac #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sample_i,
  output logic         bit_o
);

  logic [W-1:0] ofs;
  logic [W+1:0] delta;
  logic [W+1:0] sigma_d;
  logic [W+1:0] sigma_q;
  logic         bit_q;

  // Offset binary: flipping the sign bit maps -2^(W-1)..2^(W-1)-1 onto 0..2^W-1.
  assign ofs     = {~sample_i[W-1], sample_i[W-2:0]};
  assign delta   = {2'b00, ofs} + {sigma_q[W+1], sigma_q[W+1], {W{1'b0}}};
  assign sigma_d = delta + sigma_q;
  assign bit_o   = bit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sigma_q <= {2'b01, {W{1'b0}}};
      bit_q   <= 1'b0;
    end else begin
      sigma_q <= sigma_d;
      bit_q   <= sigma_q[W+1];
    end
  end

endmodule

// File: rtl/audio_mixer_seq.sv
// Time-multiplexed N-channel stereo mixer with Z80 register port and sigma-delta outputs.
// Define AUDIO_MIXER_READBACK_EN to enable CPU readback of index and registers.
module audio_mixer_seq
  import audio_mixer_pkg::*;
#(
  parameter int         NCH     = 8,
  parameter int         IW      = 8,
  parameter int         VW      = 4,
  parameter int         OW      = 12,
  parameter logic [7:0] IDXPORT = IDXPORT_DEF,
  parameter logic [7:0] DATPORT = DATPORT_DEF
) (
  input  logic              clk,
  input  logic              mrst_n,
  input  logic [7:0]        a,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              oe_n,
  input  logic [NCH*IW-1:0] ch_in,
  output logic [OW-1:0]     sample_l,
  output logic [OW-1:0]     sample_r,
  output logic              sample_valid,
  output logic [1:0]        clip,
  output logic              output_left,
  output logic              output_right
);

  localparam int CB = clog2(NCH);
  localparam int CW = (CB < 1) ? 1 : CB;
  localparam int AW = IW + VW + CB + 1;
  localparam int SH = IW + VW - OW;
  localparam logic signed [AW-1:0] MAXV = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic [7:0]    idx_q;
  logic          prev_q;
  logic [VW-1:0] vol_l_q [NCH];
  logic [VW-1:0] vol_r_q [NCH];
  logic [1:0]    clip_q;
  logic [1:0]    clip_d;

  logic strb, acc_evt, at_idx, at_dat, idx_wr, dat_wr, dat_rd, clip_clr;

  // An access is the first cycle of a strobe; held strobes must not repeat it.
  assign strb     = ~iorq_n & (~wr_n | ~rd_n);
  assign acc_evt  = strb & ~prev_q;
  assign at_idx   = (a == IDXPORT);
  assign at_dat   = (a == DATPORT);
  assign idx_wr   = acc_evt & ~wr_n & at_idx;
  assign dat_wr   = acc_evt & ~wr_n & at_dat;
  assign clip_clr = dat_wr & (idx_q == CLIPIDX);

`ifdef AUDIO_MIXER_READBACK_EN
  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'h00;
    if (idx_q == CLIPIDX) rd_data = {6'b000000, clip_q};
    for (int i = 0; i < NCH; i++) begin
      if (idx_q == 8'(2*i))   rd_data = 8'(vol_l_q[i]);
      if (idx_q == 8'(2*i+1)) rd_data = 8'(vol_r_q[i]);
    end
  end

  assign dat_rd = acc_evt & wr_n & ~rd_n & at_dat;
  assign oe_n   = ~(~iorq_n & ~rd_n & (at_idx | at_dat));
  assign dout   = oe_n ? 8'h00 : (at_idx ? idx_q : rd_data);
`else
  assign dat_rd = 1'b0;
  assign oe_n   = 1'b1;
  assign dout   = 8'h00;
`endif

  always_ff @(posedge clk or negedge mrst_n) begin
    if (!mrst_n) begin
      prev_q <= 1'b0;
      idx_q  <= 8'h00;
      for (int i = 0; i < NCH; i++) begin
        vol_l_q[i] <= '1;
        vol_r_q[i] <= '1;
      end
    end else begin
      prev_q <= strb;
      if (idx_wr) idx_q <= din;
      else if (dat_wr || dat_rd) idx_q <= idx_q + 8'd1;
      if (dat_wr) begin
        for (int i = 0; i < NCH; i++) begin
          if (idx_q == 8'(2*i))   vol_l_q[i] <= din[VW-1:0];
          if (idx_q == 8'(2*i+1)) vol_r_q[i] <= din[VW-1:0];
        end
      end
    end
  end

  scan_state_t          state_q;
  logic [CW-1:0]        c_q;
  logic signed [IW-1:0] shadow_q [NCH];
  logic signed [AW-1:0] acc_l_q, acc_r_q;
  logic [OW-1:0]        sample_l_q, sample_r_q;
  logic                 valid_q;

  logic signed [IW-1:0] smp_sel;
  logic [VW-1:0]        vl_sel, vr_sel;
  logic signed [AW-1:0] prod_l, prod_r, shifted_l, shifted_r;
  logic [OW:0]          sat_l, sat_r;

  function automatic logic [OW:0] sat_fn(input logic signed [AW-1:0] v);
    if (v > MAXV) return {1'b1, MAXV[OW-1:0]};
    if (v < MINV) return {1'b1, MINV[OW-1:0]};
    return {1'b0, v[OW-1:0]};
  endfunction

  always_comb begin
    smp_sel = '0;
    vl_sel  = '0;
    vr_sel  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (c_q == CW'(i)) begin
        smp_sel = shadow_q[i];
        vl_sel  = vol_l_q[i];
        vr_sel  = vol_r_q[i];
      end
    end
  end

  // Volumes are unsigned, so they get a zero sign bit before the signed multiply.
  assign prod_l    = AW'(smp_sel) * AW'($signed({1'b0, vl_sel}));
  assign prod_r    = AW'(smp_sel) * AW'($signed({1'b0, vr_sel}));
  assign shifted_l = acc_l_q >>> SH;
  assign shifted_r = acc_r_q >>> SH;
  assign sat_l     = sat_fn(shifted_l);
  assign sat_r     = sat_fn(shifted_r);

  // A saturation in the same cycle as a CPU clear wins.
  assign clip_d = (clip_clr ? 2'b00 : clip_q)
                | ((state_q == DUMP) ? {sat_r[OW], sat_l[OW]} : 2'b00);

  always_ff @(posedge clk or negedge mrst_n) begin
    if (!mrst_n) begin
      state_q    <= ACC;
      c_q        <= '0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      sample_l_q <= '0;
      sample_r_q <= '0;
      valid_q    <= 1'b0;
      clip_q     <= 2'b00;
      for (int i = 0; i < NCH; i++) shadow_q[i] <= '0;
    end else begin
      valid_q <= 1'b0;
      clip_q  <= clip_d;
      case (state_q)
        ACC: begin
          acc_l_q <= acc_l_q + prod_l;
          acc_r_q <= acc_r_q + prod_r;
          if (c_q == CW'(NCH-1)) state_q <= DUMP;
          else c_q <= c_q + CW'(1);
        end
        DUMP: begin
          sample_l_q <= sat_l[OW-1:0];
          sample_r_q <= sat_r[OW-1:0];
          valid_q    <= 1'b1;
          acc_l_q    <= '0;
          acc_r_q    <= '0;
          c_q        <= '0;
          state_q    <= ACC;
          for (int i = 0; i < NCH; i++) shadow_q[i] <= ch_in[i*IW +: IW];
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign sample_l     = sample_l_q;
  assign sample_r     = sample_r_q;
  assign sample_valid = valid_q;
  assign clip         = clip_q;

  sd_dac #(.W(OW)) u_dac_l (
    .clk      (clk),
    .rst_n    (mrst_n),
    .sample_i (sample_l_q),
    .bit_o    (output_left)
  );

  sd_dac #(.W(OW)) u_dac_r (
    .clk      (clk),
    .rst_n    (mrst_n),
    .sample_i (sample_r_q),
    .bit_o    (output_right)
  );

endmodule

// File: doc/audio_mixer_seq.md
# audio_mixer_seq

Parametrised, time-multiplexed N-channel stereo mixer with per-channel left/right volume, saturating output and per-side first-order sigma-delta DACs. Successor to the fixed 8-bit on/off panner: channel count, sample width, volume depth and output width are parameters, and panning becomes a volume per side. It sits between the sound sources (AY, beeper, Specdrum, MIDI) and the board audio pins, with its control registers on the Z80 I/O bus.

## Interface
- NCH, 8: number of input channels, 1..64
- IW, 8: input sample width, signed two's complement
- VW, 4: volume width, unsigned; 2^VW-1 is unity
- OW, 12: mixed output width, signed; constraint OW ≤ IW+VW
- IDXPORT, 8'hF6: I/O address of the index register
- DATPORT, 8'hF7: I/O address of the data port
- clk  in  1  system clock
- mrst_n  in  1  reset, asynchronous, active-low
- a  in  8  Z80 address low byte
- iorq_n, rd_n, wr_n  in  1 each  Z80 bus strobes
- din  in  8  CPU write data
- dout  out  8  CPU read data
- oe_n  out  1  low while the block drives dout
- ch_in  in  NCH*IW  packed samples; channel i is at [i*IW +: IW]
- sample_l, sample_r  out  OW  saturated mix, signed
- sample_valid  out  1  one-cycle pulse when sample_l/r update
- clip  out  2  sticky clip flags {right, left}
- output_left, output_right  out  1  sigma-delta bitstreams

## Operation
**Registers**
- 8-bit index register, written at IDXPORT.
- Index 2i: vol_l[i]. Index 2i+1: vol_r[i].
- Index 0xFE: clip status, bits[1:0] = {right, left}. Any data write clears both flags.
- Other indices: writes are ignored; reads return 0x00.

**CPU access**
- An access is the first cycle with a == port, iorq_n = 0, and wr_n = 0 or rd_n = 0. Detection uses a registered previous-strobe copy.
- Write data is committed on that cycle only, so held strobes do not repeat it.
- After each data-port access the index increments (mod 256). IDXPORT accesses do not increment.

**Scan FSM**
- Two states, ACC and DUMP.
- ACC (counter c = 0..NCH-1):
  - acc_l += shadow[c]·vol_l[c]
  - acc_r += shadow[c]·vol_r[c]
  - The product is signed IW × unsigned VW.
  - The accumulator is IW+VW+clog2(NCH)+1 bits and can never overflow.
- DUMP (one cycle):
  - result = acc >>> (IW+VW-OW), then clipped to [-2^(OW-1), 2^(OW-1)-1].
  - Registers sample_l/r and pulses sample_valid.
  - Sets clip[x] if that side saturated.
  - Clears acc, copies ch_in into shadow, resets c to 0.
- Frame period is NCH+1 cycles.
- A volume write mid-frame takes effect at that channel's next ACC cycle.

**DAC**
- sample converted to offset binary by inverting its MSB.
- Accumulator is OW+2 bits; its reset value is 1<<OW.
- The output bit is the registered accumulator MSB.

## Timing
- Reset values:
  - All volumes = 2^VW-1; index = 0; clip = 0.
  - sample_l/r = 0; sample_valid = 0.
  - output_left/right = 0; oe_n = 1; dout = 0.
  - FSM in ACC with c = 0, shadow = 0, acc = 0.
- Latency: ch_in sampled in a DUMP cycle appears on sample_l/r at the end of the next DUMP cycle, NCH+1 cycles later.
- The DAC adds 1 cycle to the bitstream.
- A clip-clear write and a saturation in the same cycle: the set wins.
- Reset is asynchronous. Asserting it mid-frame discards the partial frame; the first sample_valid comes NCH+1 cycles after release.

## Configuration
- AUDIO_MIXER_READBACK_EN defined:
  - A read at DATPORT returns the register at index (volumes zero-extended) and increments the index.
  - A read at IDXPORT returns the index.
  - oe_n goes low combinationally during the read.
- Not defined: oe_n is tied to 1, dout to 0, and reads have no side effects.

## Structure
- audio_mixer_pkg holds:
  - Default port addresses, and CLIPIDX = 8'hFE.
  - The clog2 function.
  - State encoding ACC/DUMP.
- Sub-module sd_dac, parameter W: the sigma-delta DAC, instantiated twice.

## Test plan
All scenarios use default parameters.
- Reset release: sample_valid every 9 cycles, all volumes read back 0x0F, sample_l = sample_r = 0.
- ch0 = 0x40, others 0, volumes unity: sample_l = sample_r = 960.
- ch0 = 0x40, write vol_r[0] = 0 via index 1: sample_l = 960, sample_r = 0.
- All channels 127: sample_l = 2047, clip = 2'b11.
  - Write to index 0xFE clears clip; it re-sets on the next DUMP.
- All channels -128: sample_l = -2048, clip set.
- Hold wr_n low for 6 cycles on DATPORT: exactly one register is written and the index advances by 1.
- Assert mrst_n mid-frame: all outputs return to their reset values at once.
- sample = 0: output_left duty is 50% ±1/4096 over 4096 cycles.
